// File: rtl/fifo_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_tx_pkg
//   Shared types and constants for the FIFO transmit serializer.
//   - tx_state_e : byte-engine FSM states
//   - ACK_LVL / NACK_LVL : receiver acknowledge line levels
//   - cnt_width() : width big enough for both the phase timer and bit counter
// ---------------------------------------------------------------------------
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIT_LO = 3'd1,
        BIT_HI = 3'd2,
        ACK_LO = 3'd3,
        ACK_HI = 3'd4
    } tx_state_e;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    // One width serves both counters: the phase timer counts CLKDIV-1..0 and
    // the bit counter counts DATASIZE-1..0.
    function automatic int cnt_width(input int clkdiv, input int datasize);
        int m;
        m = (clkdiv > datasize) ? clkdiv : datasize;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// fifo_tx_serializer_if
//   Bundles the FIFO read handshake, the serial bus pins and the status flags
//   of the transmit serializer.
//   slave  modport : the serializer side
//   master modport : the FIFO / bus / controller side (testbench)
//   FIFO  : rdata_i, rempty_i, rinc_o
//   bus   : scl_o, sda_o, ack_i
//   ctrl  : en_i, nack_clr_i, busy_o, byte_done_o, nack_o
// ---------------------------------------------------------------------------
interface fifo_tx_serializer_if #(
    parameter int DATASIZE = 8
);
    logic                en_i;
    logic [DATASIZE-1:0] rdata_i;
    logic                rempty_i;
    logic                rinc_o;
    logic                ack_i;
    logic                nack_clr_i;
    logic                scl_o;
    logic                sda_o;
    logic                busy_o;
    logic                byte_done_o;
    logic                nack_o;

    modport slave (
        input  en_i, rdata_i, rempty_i, ack_i, nack_clr_i,
        output rinc_o, scl_o, sda_o, busy_o, byte_done_o, nack_o
    );

    modport master (
        output en_i, rdata_i, rempty_i, ack_i, nack_clr_i,
        input  rinc_o, scl_o, sda_o, busy_o, byte_done_o, nack_o
    );
endinterface

// File: rtl/tx_phase_timer.sv
// ---------------------------------------------------------------------------
// tx_phase_timer
//   Down-counter that measures one serial half-bit phase of CLKDIV cycles.
//   While run_i is low it is held loaded, so the first running cycle starts a
//   full phase. phase_end_o pulses on the last cycle of every phase and the
//   counter reloads there, so consecutive phases follow without a gap.
//   Ports: clk_i, rst_ni (sync, active-low), run_i, phase_end_o.
// ---------------------------------------------------------------------------
module tx_phase_timer #(
    parameter int CLKDIV = 4,
    parameter int CW     = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic phase_end_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!run_i || (cnt_q == '0)) begin
            cnt_q <= CW'(CLKDIV - 1);
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign phase_end_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/fifo_tx_serializer.sv
// ---------------------------------------------------------------------------
// fifo_tx_serializer
//   Read-side consumer of the async FIFO. Pops one DATASIZE-bit word, shifts
//   it MSB-first on scl/sda (I2C style), then releases sda for a 9th bit and
//   samples the receiver acknowledge on the last cycle of its high phase.
//   A NACK raises the sticky nack_o, which blocks further pops until
//   nack_clr_i (a NACK in the same cycle as the clear wins).
//
//   Ports: clk_i, rst_ni (sync, active-low), bus (fifo_tx_serializer_if.slave)
//
//   Optional build macro FIFO_TX_NACK_RETRY_EN: the first NACK of a word is
//   absorbed and the held copy is resent once without popping; a second
//   consecutive NACK then sets nack_o and pulses byte_done_o.
// ---------------------------------------------------------------------------
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int CLKDIV   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fifo_tx_serializer_if.slave  bus
);

    localparam int CW = cnt_width(CLKDIV, DATASIZE);

    tx_state_e           state_q, state_d;
    logic [DATASIZE-1:0] shreg_q;
    logic [DATASIZE-1:0] hold_q;
    logic [CW-1:0]       bit_cnt_q;
    logic                nack_q;

    logic phase_end;
    logic pop;
    logic nack_seen;
    logic nack_set;
    logic byte_done;
    logic scl;
    logic sda;
    logic busy;
    logic redo_start;

`ifdef FIFO_TX_NACK_RETRY_EN
    logic retried_q;
    logic redo_q;
    logic redo_set;
`endif

    tx_phase_timer #(
        .CLKDIV (CLKDIV),
        .CW     (CW)
    ) u_phase_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (state_q != IDLE),
        .phase_end_o (phase_end)
    );

    assign nack_seen = (bus.ack_i == NACK_LVL);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        scl        = 1'b1;
        sda        = 1'b1;
        busy       = 1'b1;
        byte_done  = 1'b0;
        nack_set   = 1'b0;
        redo_start = 1'b0;
`ifdef FIFO_TX_NACK_RETRY_EN
        redo_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                busy = 1'b0;
`ifdef FIFO_TX_NACK_RETRY_EN
                if (redo_q) begin
                    redo_start = 1'b1;
                    state_d    = BIT_LO;
                end else
`endif
                // rst_ni gating keeps the FIFO untouched while reset is held.
                if (rst_ni && bus.en_i && !bus.rempty_i && !nack_q) begin
                    pop     = 1'b1;
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                scl = 1'b0;
                sda = shreg_q[DATASIZE-1];
                if (phase_end) state_d = BIT_HI;
            end
            BIT_HI: begin
                sda = shreg_q[DATASIZE-1];
                if (phase_end) state_d = (bit_cnt_q == '0) ? ACK_LO : BIT_LO;
            end
            ACK_LO: begin
                scl = 1'b0;
                if (phase_end) state_d = ACK_HI;
            end
            ACK_HI: begin
                if (phase_end) begin
                    state_d = IDLE;
`ifdef FIFO_TX_NACK_RETRY_EN
                    if (nack_seen && !retried_q) begin
                        redo_set = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                        nack_set  = nack_seen;
                    end
`else
                    byte_done = 1'b1;
                    nack_set  = nack_seen;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word data carries no reset: it is only observed after a fresh load.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            shreg_q <= bus.rdata_i;
            hold_q  <= bus.rdata_i;
        end else if (redo_start) begin
            shreg_q <= hold_q;
        end else if ((state_q == BIT_HI) && phase_end) begin
            shreg_q <= {shreg_q[DATASIZE-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bit_cnt_q <= '0;
        end else if (pop || redo_start) begin
            bit_cnt_q <= CW'(DATASIZE - 1);
        end else if ((state_q == BIT_HI) && phase_end && (bit_cnt_q != '0)) begin
            bit_cnt_q <= bit_cnt_q - CW'(1);
        end
    end

    // Set has priority over clear so a NACK is never lost to a racing clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            nack_q <= 1'b0;
        end else if (nack_set) begin
            nack_q <= 1'b1;
        end else if (bus.nack_clr_i) begin
            nack_q <= 1'b0;
        end
    end

`ifdef FIFO_TX_NACK_RETRY_EN
    // retried_q: this word already had its one retransmission.
    // redo_q   : a retransmission is pending for the next IDLE cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retried_q <= 1'b0;
            redo_q    <= 1'b0;
        end else begin
            if (pop)        retried_q <= 1'b0;
            if (redo_start) redo_q    <= 1'b0;
            if (redo_set) begin
                retried_q <= 1'b1;
                redo_q    <= 1'b1;
            end
        end
    end
`endif

    assign bus.rinc_o      = pop;
    assign bus.scl_o       = scl;
    assign bus.sda_o       = sda;
    assign bus.busy_o      = busy;
    assign bus.byte_done_o = byte_done;
    assign bus.nack_o      = nack_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
module tb_fifo_tx_serializer;

    localparam int DW = 8;
    localparam int CD = 4;
    localparam int WORD_CYC = 2 * CD * (DW + 1);

    logic clk = 1'b0;
    logic rst_ni;

    fifo_tx_serializer_if #(.DATASIZE(DW)) bus ();

    fifo_tx_serializer #(.DATASIZE(DW), .CLKDIV(CD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] word;
        logic [8:0]    bits;
    } vec_t;

    logic [DW-1:0] fifo_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pop_cnt, done_cnt, bits_seen, scl_low, busy_cnt;
    int   bad_pop = 0;
    int   last_pop, last_done;
    int   pop_t[4];
    logic pop_scl[4];
    logic [31:0] sda_log;
    logic prev_scl = 1'b1;
    logic s_rinc, s_scl, s_sda, s_busy, s_done, s_nack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.rempty_i = (fifo_q.size() == 0);
        bus.rdata_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic clear_log();
        pop_cnt = 0; done_cnt = 0; bits_seen = 0; scl_low = 0; busy_cnt = 0;
        last_pop = -1; last_done = -1; sda_log = '0;
    endtask

    // One clock cycle: sample outputs at the falling edge, then let the
    // rising edge happen and update the FIFO model.
    task automatic step();
        @(negedge clk);
        s_rinc = bus.rinc_o;  s_scl  = bus.scl_o;       s_sda  = bus.sda_o;
        s_busy = bus.busy_o;  s_done = bus.byte_done_o; s_nack = bus.nack_o;
        if (s_rinc) begin
            if (pop_cnt < 4) begin
                pop_t[pop_cnt]   = cyc;
                pop_scl[pop_cnt] = s_scl;
            end
            pop_cnt++;
            last_pop = cyc;
            if (bus.rempty_i) bad_pop++;
        end
        if (prev_scl && !s_scl) begin
            sda_log = {sda_log[30:0], s_sda};
            bits_seen++;
        end
        prev_scl = s_scl;
        if (s_done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (!s_scl) scl_low++;
        if (s_busy) busy_cnt++;
        @(posedge clk);
        if (s_rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
        cyc++;
        #1;
        drive_fifo();
    endtask

    task automatic run_until_done(input int n, input int bound);
        int g;
        g = 0;
        while (done_cnt < n && g < bound) begin
            step();
            g++;
        end
    endtask

    vec_t vecs[5];
    int   clr_cyc;

    initial begin
        vecs[0] = '{word: 8'hA5, bits: 9'b101001011};
        vecs[1] = '{word: 8'h3C, bits: 9'b001111001};
        vecs[2] = '{word: 8'hC3, bits: 9'b110000111};
        vecs[3] = '{word: 8'h00, bits: 9'b000000001};
        vecs[4] = '{word: 8'hFF, bits: 9'b111111111};

        rst_ni = 1'b0;
        bus.en_i = 1'b1;
        bus.ack_i = 1'b0;
        bus.nack_clr_i = 1'b0;
        drive_fifo();
        clear_log();

        // Reset state
        repeat (3) step();
        check("rst_scl", s_scl, 1);
        check("rst_sda", s_sda, 1);
        check("rst_rinc", s_rinc, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_nack", s_nack, 0);
        rst_ni = 1'b1;

        // Empty FIFO for 200 cycles
        clear_log();
        repeat (200) step();
        check("empty_pops", pop_cnt, 0);
        check("empty_scl_low", scl_low, 0);
        check("empty_busy", busy_cnt, 0);
        check("empty_sda", s_sda, 1);

        // Single words from the table
        for (int i = 0; i < 5; i++) begin
            clear_log();
            fifo_q.push_back(vecs[i].word);
            drive_fifo();
            run_until_done(1, 200);
            repeat (3) step();
            check($sformatf("v%0d_bits", i), sda_log[8:0], vecs[i].bits);
            check($sformatf("v%0d_nbits", i), bits_seen, 9);
            check($sformatf("v%0d_done_lat", i), last_done - last_pop, WORD_CYC);
            check($sformatf("v%0d_pops", i), pop_cnt, 1);
            check($sformatf("v%0d_dones", i), done_cnt, 1);
            check($sformatf("v%0d_nack", i), s_nack, 0);
            check($sformatf("v%0d_idle_busy", i), s_busy, 0);
        end

        // Back-to-back words
        clear_log();
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'hC3);
        drive_fifo();
        run_until_done(2, 400);
        repeat (3) step();
        check("b2b_pops", pop_cnt, 2);
        check("b2b_spacing", pop_t[1] - pop_t[0], WORD_CYC + 1);
        check("b2b_gap_scl", pop_scl[1], 1);
        check("b2b_bits", sda_log[17:0], {9'b001111001, 9'b110000111});

        // en_i dropped mid-word: word completes, no second pop
        clear_log();
        fifo_q.push_back(8'h12);
        fifo_q.push_back(8'h34);
        drive_fifo();
        step();
        bus.en_i = 1'b0;
        run_until_done(1, 200);
        repeat (20) step();
        check("en_off_pops", pop_cnt, 1);
        check("en_off_bits", sda_log[8:0], 9'b000100101);
        check("en_off_left", fifo_q.size(), 1);
        fifo_q.delete();
        drive_fifo();
        bus.en_i = 1'b1;

`ifdef FIFO_TX_NACK_RETRY_EN
        // NACK then ACK: one pop, word sent twice, one byte_done
        clear_log();
        fifo_q.push_back(8'h81);
        drive_fifo();
        bus.ack_i = 1'b1;
        step();
        while (last_pop >= 0 && cyc <= last_pop + WORD_CYC && cyc < 100000) step();
        bus.ack_i = 1'b0;
        run_until_done(1, 300);
        repeat (3) step();
        check("retry_pops", pop_cnt, 1);
        check("retry_dones", done_cnt, 1);
        check("retry_lat", last_done - last_pop, 2 * WORD_CYC + 1);
        check("retry_bits", sda_log[17:0], {9'b100000011, 9'b100000011});
        check("retry_nack", s_nack, 0);
`else
        // NACK on 0x55 with 0x66 queued
        clear_log();
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h66);
        drive_fifo();
        bus.ack_i = 1'b1;
        run_until_done(1, 200);
        bus.ack_i = 1'b0;
        step();
        check("nack_set", s_nack, 1);
        repeat (50) step();
        check("nack_block_pops", pop_cnt, 1);
        check("nack_block_left", fifo_q.size(), 1);
        check("nack_bits", sda_log[8:0], 9'b010101011);
        clr_cyc = cyc;
        bus.nack_clr_i = 1'b1;
        step();
        bus.nack_clr_i = 1'b0;
        step();
        check("clr_pops", pop_cnt, 2);
        check("clr_pop_cyc", last_pop - clr_cyc, 1);
        // 0x66 is NACKed with nack_clr_i high in the very same cycle
        bus.ack_i = 1'b1;
        while (cyc < last_pop + WORD_CYC && cyc < clr_cyc + 500) step();
        bus.nack_clr_i = 1'b1;
        step();
        bus.nack_clr_i = 1'b0;
        bus.ack_i = 1'b0;
        check("race_done_cyc", last_done - last_pop, WORD_CYC);
        step();
        check("race_nack_kept", s_nack, 1);
        bus.nack_clr_i = 1'b1;
        step();
        bus.nack_clr_i = 1'b0;
        step();
        check("nack_cleared", s_nack, 0);
`endif

        // Reset during bit 4 of 0xF0, then 0x0F must be the first word sent
        clear_log();
        fifo_q.push_back(8'hF0);
        drive_fifo();
        while (bits_seen < 5 && cyc < 100000) begin
            step();
            if (pop_cnt == 0 && cyc > 90000) break;
        end
        fifo_q.push_back(8'h0F);
        drive_fifo();
        rst_ni = 1'b0;
        step();
        step();
        check("mid_rst_scl", s_scl, 1);
        check("mid_rst_sda", s_sda, 1);
        check("mid_rst_busy", s_busy, 0);
        check("mid_rst_rinc", s_rinc, 0);
        rst_ni = 1'b1;
        clear_log();
        run_until_done(1, 200);
        repeat (3) step();
        check("post_rst_pops", pop_cnt, 1);
        check("post_rst_bits", sda_log[8:0], 9'b000011111);
        check("post_rst_empty", fifo_q.size(), 0);
        check("never_pop_empty", bad_pop, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
